// File: rtl/pc_trace_monitor.sv
// Execution trace monitor: captures fetched PCs into a circular buffer until
// the program halts or the cycle budget runs out, then streams them oldest first.
module pc_trace_monitor #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             pc,
   input  logic [31:0]             inst,
   output logic                    running,
   output logic                    halted,
   output logic                    timed_out,
   output logic [15:0]             cycle_count,
   output logic [$clog2(DEPTH):0]  trace_count,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [31:0]             rd_data,
   output logic                    rd_last
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);
   localparam logic [15:0]   LP_TO   = 16'(TIMEOUT);

   typedef enum logic [1:0] {
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [31:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_trace_count;
   logic [CW-1:0] r_remain;
   logic [15:0]   r_cycle_count;
   logic          r_halted;
   logic          r_timed_out;

   logic [PW-1:0] w_wr_inc;
   logic [CW-1:0] w_tc_inc;
   logic [15:0]   w_cc_inc;
   logic          w_halt;
   logic          w_tmo;
   logic          w_stop;
   logic          w_last;

   always_comb begin
      w_wr_inc = r_wr_ptr + PW'(1);
      w_cc_inc = r_cycle_count + 16'd1;
      w_tc_inc = (r_trace_count == LP_FULL) ? r_trace_count
                                            : r_trace_count + CW'(1);
      w_halt   = (inst == 32'h0);
      w_tmo    = (w_cc_inc == LP_TO);
      w_stop   = w_halt | w_tmo;
      w_last   = (r_remain == CW'(1));
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_RUN;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      running     = 1'b0;
      rd_valid    = 1'b0;
      rd_data     = 32'h0;
      rd_last     = 1'b0;
      unique case (r_state)
         S_RUN: begin
            running = 1'b1;
            if (w_stop) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            rd_valid = 1'b1;
            rd_data  = r_mem[r_rd_ptr];
            rd_last  = w_last;
            if (rd_ready && w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset && r_state == S_RUN) r_mem[r_wr_ptr] <= pc;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_trace_count <= '0;
         r_remain      <= '0;
         r_cycle_count <= '0;
         r_halted      <= 1'b0;
         r_timed_out   <= 1'b0;
      end else begin
         unique case (r_state)
            S_RUN: begin
               r_wr_ptr      <= w_wr_inc;
               r_cycle_count <= w_cc_inc;
               r_trace_count <= w_tc_inc;
               if (w_stop) begin
                  // halt has priority when both stop causes coincide
                  r_halted    <= w_halt;
                  r_timed_out <= ~w_halt;
                  r_rd_ptr    <= (w_tc_inc < LP_FULL) ? '0 : w_wr_inc;
                  r_remain    <= w_tc_inc;
               end
            end
            S_DRAIN: begin
               if (rd_ready) begin
                  r_rd_ptr <= r_rd_ptr + PW'(1);
                  r_remain <= r_remain - CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign halted      = r_halted;
   assign timed_out   = r_timed_out;
   assign cycle_count = r_cycle_count;
   assign trace_count = r_trace_count;

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Bench for pc_trace_monitor: directed and random runs checked against
// a queue model of captured PCs and the stop rules.
module tb_pc_trace_monitor;

   localparam int DEPTH   = 16;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        rd_ready;
   logic        running;
   logic        halted;
   logic        timed_out;
   logic [15:0] cycle_count;
   logic [4:0]  trace_count;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        rd_last;

   always #5 clk = ~clk;

   pc_trace_monitor #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .inst        (inst),
      .running     (running),
      .halted      (halted),
      .timed_out   (timed_out),
      .cycle_count (cycle_count),
      .trace_count (trace_count),
      .rd_valid    (rd_valid),
      .rd_ready    (rd_ready),
      .rd_data     (rd_data),
      .rd_last     (rd_last)
   );

   int          total = 0;
   int          bad   = 0;
   logic [31:0] cap[$];
   bit          exp_halt;
   int          exp_cc;
   int          pat[12] = '{1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      rd_ready = 1'b0;
      @(negedge clk);
      chk("rst_running", 32'(running), 32'd1);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_timed_out", 32'(timed_out), 32'd0);
      chk("rst_cycle_count", 32'(cycle_count), 32'd0);
      chk("rst_trace_count", 32'(trace_count), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_rd_last", 32'(rd_last), 32'd0);
      reset = 1'b0;
      cap.delete();
   endtask

   task automatic capture(input int halt_at, input logic [31:0] base,
                          input bit rnd);
      int          k    = 0;
      bit          stop = 1'b0;
      logic [31:0] p;
      logic [31:0] w;
      int          n;
      while (!stop) begin
         chk("run_running", 32'(running), 32'd1);
         chk("run_cycle_count", 32'(cycle_count), 32'(k));
         p = rnd ? $urandom : base + 32'(4 * k);
         w = (k + 1 == halt_at) ? 32'h0 : ($urandom | 32'h1);
         pc   = p;
         inst = w;
         cap.push_back(p);
         k++;
         exp_halt = (w == 32'h0);
         stop     = exp_halt || (k == TIMEOUT);
         @(negedge clk);
      end
      exp_cc = k;
      n      = (k > DEPTH) ? DEPTH : k;
      inst   = $urandom | 32'h1;
      chk("stop_running", 32'(running), 32'd0);
      chk("stop_halted", 32'(halted), 32'(exp_halt));
      chk("stop_timed_out", 32'(timed_out), 32'(!exp_halt));
      chk("stop_cycle_count", 32'(cycle_count), 32'(k));
      chk("stop_trace_count", 32'(trace_count), 32'(n));
   endtask

   task automatic drain(input int mode, input int stop_at);
      int n     = (cap.size() > DEPTH) ? DEPTH : cap.size();
      int first = cap.size() - n;
      int lim   = (stop_at < 0) ? n : stop_at;
      int idx   = 0;
      int cyc   = 0;
      bit r;
      while (idx < lim && cyc < 400) begin
         chk("drain_valid", 32'(rd_valid), 32'd1);
         chk("drain_data", rd_data, cap[first+idx]);
         chk("drain_last", 32'(rd_last), 32'(idx == n - 1));
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc < 12) ? (pat[cyc] != 0) : 1'b1;
            default: r = 1'($urandom_range(0, 1));
         endcase
         rd_ready = r;
         @(negedge clk);
         if (r) idx++;
         cyc++;
      end
      rd_ready = 1'b0;
      chk("drain_xfers", 32'(idx), 32'(lim));
      if (stop_at < 0) begin
         chk("done_valid", 32'(rd_valid), 32'd0);
         chk("done_data", rd_data, 32'd0);
         chk("done_last", 32'(rd_last), 32'd0);
         chk("done_running", 32'(running), 32'd0);
         chk("done_halted", 32'(halted), 32'(exp_halt));
         chk("done_cycle_count", 32'(cycle_count), 32'(exp_cc));
         chk("done_trace_count", 32'(trace_count), 32'(n));
      end
   endtask

   initial begin
      reset    = 1'b1;
      pc       = 32'h0;
      inst     = 32'h1;
      rd_ready = 1'b0;
      @(negedge clk);

      // halt without wrap, then DONE ignores further activity
      do_reset();
      capture(5, 32'h0, 1'b0);
      drain(0, -1);
      pc       = 32'hDEAD_BEEC;
      inst     = 32'h0;
      rd_ready = 1'b1;
      repeat (3) @(negedge clk);
      rd_ready = 1'b0;
      chk("hold_cycle_count", 32'(cycle_count), 32'd5);
      chk("hold_trace_count", 32'(trace_count), 32'd5);
      chk("hold_valid", 32'(rd_valid), 32'd0);
      chk("hold_running", 32'(running), 32'd0);

      // timeout with wrap
      do_reset();
      capture(0, 32'h0, 1'b0);
      drain(0, -1);

      // halt and timeout on the same capture
      do_reset();
      capture(TIMEOUT, 32'h0, 1'b1);
      drain(0, -1);

      // backpressure
      do_reset();
      capture(8, 32'h200, 1'b0);
      drain(1, -1);

      // exactly DEPTH captures
      do_reset();
      capture(16, 32'h100, 1'b0);
      drain(0, -1);

      // reset mid-drain, then a fresh short run
      do_reset();
      capture(5, 32'h40, 1'b0);
      drain(0, 2);
      do_reset();
      capture(3, 32'h800, 1'b0);
      drain(0, -1);

      for (int t = 0; t < 5; t++) begin
         do_reset();
         capture(int'($urandom_range(1, 80)), 32'h0, 1'b1);
         drain(2, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_trace_monitor.md
Name: pc_trace_monitor

Overview:
- Synthesizable execution monitor that sits directly downstream of the single-cycle `machine`.
- Every cycle it samples the fetched PC (`{PC_reg.q, 2'b00}`) and the current instruction word into a circular trace buffer.
- It stops capture when the program halts (instruction word all zero) or when a cycle budget expires.
- After stopping, it streams the captured PCs, oldest first, over a valid/ready interface to the bench or a host-side dumper.

Parameters:
- DEPTH, 16, trace buffer entries; must be a power of two, at least 2.
- TIMEOUT, 64, maximum capture cycles before forced stop; range 1..65535.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  input  32  byte address of the instruction executing this cycle.
- inst  input  32  instruction word executing this cycle.
- running  output  1  high while in RUN.
- halted  output  1  capture stopped because inst == 32'h00000000.
- timed_out  output  1  capture stopped because TIMEOUT was reached.
- cycle_count  output  16  number of cycles captured.
- trace_count  output  $clog2(DEPTH)+1  valid entries in the buffer; saturates at DEPTH.
- rd_valid  output  1  rd_data holds a trace entry.
- rd_ready  input  1  consumer accepts rd_data this cycle.
- rd_data  output  32  trace PC; 0 when rd_valid is low.
- rd_last  output  1  rd_data is the newest (final) entry.

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `reset` is synchronous and active-high; it overrides all other activity, including mid-stream.
- Reset values: state RUN, running=1, halted=0, timed_out=0, cycle_count=0, trace_count=0, rd_valid=0, rd_data=0, rd_last=0, wr_ptr=0, rd_ptr=0.
- States: RUN -> DRAIN -> DONE. DONE is held until reset.
- RUN, on every edge with reset low:
  - Write pc to mem[wr_ptr].
  - wr_ptr = wr_ptr+1, mod DEPTH.
  - cycle_count += 1.
  - trace_count += 1, saturating at DEPTH.
- Stop conditions, evaluated on the same edge as the capture (the stopping cycle's pc is always captured):
  - inst == 0: halted <= 1, go to DRAIN.
  - else if cycle_count+1 == TIMEOUT: timed_out <= 1, go to DRAIN.
  - Both true on the same edge: halt wins; halted=1, timed_out=0.
  - running drops to 0 in the same edge the state leaves RUN.
- Entering DRAIN sets rd_ptr:
  - 0 if trace_count < DEPTH (no wrap).
  - wr_ptr otherwise (oldest entry after wrap).
  - Use the post-update values for both decisions.
- DRAIN output rules:
  - rd_valid = 1 and rd_data = mem[rd_ptr], combinational from rd_ptr.
  - rd_last = 1 when the remaining count == 1.
- DRAIN handshake:
  - A transfer occurs when rd_valid && rd_ready; rd_ptr advances mod DEPTH and the remaining count decrements.
  - With rd_ready low, rd_data and rd_last are held stable.
  - The transfer with rd_last high moves the block to DONE.
- DONE:
  - rd_valid=0, rd_data=0, rd_last=0.
  - halted, timed_out, cycle_count and trace_count keep their final values.
  - pc and inst are ignored.
- cycle_count never exceeds TIMEOUT. The buffer is never empty in DRAIN (at least one capture precedes any stop).
- pc and inst are sampled as given; low address bits are not checked.
- Reset asserted during DRAIN or DONE: next edge returns all reset values and capture restarts immediately; no partial stream resumes.

Test Plan:
1. Halt without wrap:
   - Stimulus: pc = 0x0, 0x4, 0x8, 0xC, 0x10; inst nonzero except 0 at pc 0x10; rd_ready=1.
   - Required: halted=1, timed_out=0, cycle_count=5, trace_count=5.
   - Required stream: 0x0, 0x4, 0x8, 0xC, 0x10; rd_last only on 0x10; then DONE with rd_valid=0.
2. Timeout with wrap:
   - Stimulus: pc = 4*n for n=0..; inst never zero.
   - Required: timed_out=1 after the 64th capture, cycle_count=64, trace_count=16.
   - Required stream: 0xC0 through 0xFC in order, 16 entries, rd_last on 0xFC.
3. Simultaneous stop: inst=0 on the 64th capture -> halted=1, timed_out=0, cycle_count=64.
4. Backpressure:
   - Stimulus: halt after 8 captures; rd_ready pattern 1,0,0,1,0,1,1,1,1,1,1,1.
   - Required: rd_data/rd_last stable while stalled; exactly 8 transfers, no duplicates or drops; order preserved.
5. Exact DEPTH boundary:
   - Stimulus: halt on the 16th capture, pcs 0x100..0x13C.
   - Required: trace_count=16; first streamed 0x100, last 0x13C; rd_ptr wraps to 0 cleanly.
6. Reset mid-drain:
   - Stimulus: after 2 of 5 transfers, hold reset high for 1 cycle.
   - Required: all outputs at reset values; a fresh 3-cycle halting run then reports cycle_count=3 and streams only the new PCs.
